// File: rtl/eth_tx_frame_fifo_pkg.sv
// Shared widths and write-FSM encodings for the Ethernet TX frame FIFO.
package eth_pkg;
    localparam int AXIS_DATA_W = 8;
    localparam int ENTRY_W     = AXIS_DATA_W + 1;

    typedef enum logic {
        STORE = 1'b0,
        DROP  = 1'b1
    } wr_state_e;
endpackage

// File: rtl/eth_tx_frame_fifo_if.sv
// Byte-wide AXI-Stream handshake bundle.
interface eth_tx_frame_fifo_if;
    import eth_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_frame_fifo_sdp_ram.sv
// Simple dual-port RAM, registered read, no reset so it maps onto block RAM.
module eth_sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward byte FIFO: a frame is released only once its tlast byte is stored;
// frames larger than the whole buffer are discarded.
module eth_tx_frame_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int CNT_W      = 12
) (
    input  logic                       Clk,
    input  logic                       Rstn,
    eth_tx_frame_fifo_if.slave         AXIS_In,
    eth_tx_frame_fifo_if.master        AXIS_Out,
    output logic [CNT_W-1:0]           Frame_Cnt,
    output logic                       Drop_Pulse
);
    localparam int               PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr, wr_commit, rd_ptr;
    logic               rdy_en, full, in_rdy;
    logic               ram_we, commit, drop_done;
    logic               readable, rd_en, rd_vld, pop;
    logic [1:0]         sk_cnt;
    logic [2:0]         occ;
    logic [ENTRY_W-1:0] rdata, sk0, sk1;

    assign full            = (wr_ptr - rd_ptr) == DEPTH;
    assign AXIS_In.tready  = in_rdy;

    eth_sdp_ram #(.WIDTH(ENTRY_W), .ADDR_W(DEPTH_LOG2)) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata ({AXIS_In.tlast, AXIS_In.tdata}),
        .re    (rd_en),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) state_q <= STORE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_rdy    = 1'b0;
        ram_we    = 1'b0;
        commit    = 1'b0;
        drop_done = 1'b0;
        case (state_q)
            STORE: begin
                in_rdy = rdy_en && !full;
                ram_we = AXIS_In.tvalid && in_rdy;
                commit = ram_we && AXIS_In.tlast;
                // Buffer full with nothing committed: the open frame can never fit.
                if (full && wr_commit == rd_ptr) state_d = DROP;
            end
            DROP: begin
                in_rdy    = rdy_en;
                drop_done = AXIS_In.tvalid && rdy_en && AXIS_In.tlast;
                if (drop_done) state_d = STORE;
            end
            default: state_d = STORE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            rdy_en     <= 1'b0;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            Drop_Pulse <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            Drop_Pulse <= drop_done;
            if (ram_we)    wr_ptr    <= wr_ptr + PTR_W'(1);
            if (commit)    wr_commit <= wr_ptr + PTR_W'(1);
            if (drop_done) wr_ptr    <= wr_commit;
        end
    end

    // Read ahead only while the skid pair can absorb the in-flight RAM word.
    assign readable = rd_ptr != wr_commit;
    assign pop      = (sk_cnt != 2'd0) && AXIS_Out.tready;
    assign occ      = 3'(sk_cnt) + 3'(rd_vld) - 3'(pop);
    assign rd_en    = readable && (occ <= 3'd1);

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            rd_ptr <= '0;
            rd_vld <= 1'b0;
            sk_cnt <= 2'd0;
            sk0    <= '0;
            sk1    <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({rd_vld, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0) sk0 <= rdata;
                    else                sk1 <= rdata;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0    <= sk1;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) sk0 <= rdata;
                    else begin
                        sk0 <= sk1;
                        sk1 <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign AXIS_Out.tvalid = sk_cnt != 2'd0;
    assign AXIS_Out.tdata  = sk0[AXIS_DATA_W-1:0];
    assign AXIS_Out.tlast  = sk0[AXIS_DATA_W];

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) Frame_Cnt <= '0;
        else begin
            case ({commit, pop && sk0[AXIS_DATA_W]})
                2'b10:   Frame_Cnt <= Frame_Cnt + CNT_W'(1);
                2'b01:   Frame_Cnt <= Frame_Cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Scoreboard bench: dut_a uses the default 2048-byte buffer, dut_b a 64-byte buffer.
module tb_eth_tx_frame_fifo;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #10 clk = ~clk;

    eth_tx_frame_fifo_if in_a(), out_a(), in_b(), out_b();
    logic [11:0] fc_a, fc_b;
    logic        drop_a, drop_b;

    logic [7:0] d_tdata = 8'h00;
    logic       d_tvalid = 1'b0, d_tlast = 1'b0, d_sel = 1'b0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0, rnd_mode = 1'b0, rnd_bit = 1'b0;

    assign in_a.tdata   = d_tdata;
    assign in_a.tlast   = d_tlast;
    assign in_a.tvalid  = d_tvalid && !d_sel;
    assign in_b.tdata   = d_tdata;
    assign in_b.tlast   = d_tlast;
    assign in_b.tvalid  = d_tvalid && d_sel;
    assign out_a.tready = rnd_mode ? rnd_bit : rdy_a;
    assign out_b.tready = rdy_b;

    eth_tx_frame_fifo dut_a (
        .Clk(clk), .Rstn(rstn), .AXIS_In(in_a), .AXIS_Out(out_a),
        .Frame_Cnt(fc_a), .Drop_Pulse(drop_a)
    );
    eth_tx_frame_fifo #(.DEPTH_LOG2(6), .CNT_W(12)) dut_b (
        .Clk(clk), .Rstn(rstn), .AXIS_In(in_b), .AXIS_Out(out_b),
        .Frame_Cnt(fc_b), .Drop_Pulse(drop_b)
    );

    logic       o_vld[2], o_rdy[2], o_drop[2];
    logic [8:0] o_beat[2];
    assign o_vld[0]  = out_a.tvalid;
    assign o_vld[1]  = out_b.tvalid;
    assign o_rdy[0]  = out_a.tready;
    assign o_rdy[1]  = out_b.tready;
    assign o_drop[0] = drop_a;
    assign o_drop[1] = drop_b;
    assign o_beat[0] = {out_a.tlast, out_a.tdata};
    assign o_beat[1] = {out_b.tlast, out_b.tdata};

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    dchk_t      dchk_q[$];
    logic [8:0] exp_q0[$], exp_q1[$];
    int         checks = 0, fails = 0;
    int         drop_cnt[2];
    logic       prev_stall[2], in_frame[2];
    logic [8:0] prev_beat[2];

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [8:0] q_pop(input int k);
        if (k == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic q_push(input int k, input logic [8:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic post(input string name, input int act, input int exp);
        dchk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        dchk_q.push_back(c);
    endtask

    // Single checking process: directed checks and output beats are compared here.
    always @(negedge clk) begin
        dchk_t      c;
        logic [8:0] e;
        while (dchk_q.size() > 0) begin
            c = dchk_q.pop_front();
            checks++;
            if (c.act != c.exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                prev_stall[k] = 1'b0;
                in_frame[k]   = 1'b0;
            end else begin
                if (o_drop[k]) drop_cnt[k]++;
                if (prev_stall[k]) begin
                    checks++;
                    if (!o_vld[k] || o_beat[k] != prev_beat[k]) begin
                        fails++;
                        $display("FAIL stall_stable[%0d]: got vld=%0b beat=%h expected vld=1 beat=%h",
                                 k, o_vld[k], o_beat[k], prev_beat[k]);
                    end
                end
                if (in_frame[k] && o_rdy[k]) begin
                    checks++;
                    if (!o_vld[k]) begin
                        fails++;
                        $display("FAIL valid_gap[%0d]: got tvalid=0 expected 1", k);
                    end
                end
                if (o_vld[k] && o_rdy[k]) begin
                    checks++;
                    if (q_size(k) == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat[%0d]: got %h expected none", k, o_beat[k]);
                    end else begin
                        e = q_pop(k);
                        if (o_beat[k] != e) begin
                            fails++;
                            $display("FAIL out_beat[%0d]: got %h expected %h", k, o_beat[k], e);
                        end
                    end
                    in_frame[k] = !o_beat[k][8];
                end
                prev_stall[k] = o_vld[k] && !o_rdy[k];
                prev_beat[k]  = o_beat[k];
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit last,
                             input int budget, output bit ok);
        d_sel = sel; d_tdata = b; d_tlast = last; d_tvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            ok = sel ? in_b.tready : in_a.tready;
            @(posedge clk); #1;
        end
        d_tvalid = 1'b0; d_tlast = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input int len, input logic [7:0] seed, input bit keep);
        bit ok;
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            if (keep) q_push(sel ? 1 : 0, {i == len - 1, b});
        end
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            send_byte(sel, b, i == len - 1, 2000, ok);
            if (!ok) post("send_timeout", 0, 1);
        end
    endtask

    task automatic wait_drain(input int k, input int budget);
        int t = 0;
        while ((q_size(k) != 0 || o_vld[k]) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) post("drain_timeout", q_size(k), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int stall_at;
        logic [7:0] b;

        #5;
        post("rst_in_tready", in_a.tready, 0);
        post("rst_out_tvalid", out_a.tvalid, 0);
        post("rst_out_tdata", out_a.tdata, 0);
        post("rst_out_tlast", out_a.tlast, 0);
        post("rst_frame_cnt", fc_a, 0);
        post("rst_drop", drop_a, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1 post("rel_tready_before_edge", in_a.tready, 0);
        @(negedge clk);
        post("rel_tready_a", in_a.tready, 1);
        post("rel_tready_b", in_b.tready, 1);
        @(posedge clk); #1;

        // 1: single 64-byte frame, latency and counter
        rdy_a = 1'b1;
        post("t1_fc_before", fc_a, 0);
        send_frame(0, 64, 8'h00, 1);
        @(negedge clk);
        post("t1_vld_c1", out_a.tvalid, 0);
        post("t1_fc_commit", fc_a, 1);
        @(negedge clk);
        post("t1_vld_c2", out_a.tvalid, 0);
        @(negedge clk);
        post("t1_vld_c3", out_a.tvalid, 1);
        @(posedge clk); #1;
        wait_drain(0, 200);
        post("t1_fc_after", fc_a, 0);

        // 2: three frames stored while stalled, then released
        rdy_a = 1'b0;
        send_frame(0, 60, 8'h10, 1);
        send_frame(0, 1, 8'h80, 1);
        send_frame(0, 1500, 8'h33, 1);
        repeat (4) @(negedge clk);
        post("t2_fc3", fc_a, 3);
        @(posedge clk); #1;
        rdy_a = 1'b1;
        wait_drain(0, 3000);
        post("t2_fc_after", fc_a, 0);

        // 3: random output backpressure
        rnd_mode = 1'b1;
        send_frame(0, 1000, 8'h07, 1);
        wait_drain(0, 6000);
        rnd_mode = 1'b0;
        post("t3_fc_after", fc_a, 0);

        // 4: small buffer, committed frame blocks the next one
        rdy_b = 1'b0;
        send_frame(1, 40, 8'h40, 1);
        for (int i = 0; i < 30; i++) q_push(1, {i == 29, 8'hC0 + 8'(i)});
        stall_at = -1;
        for (int i = 0; i < 30; i++) begin
            b = 8'hC0 + 8'(i);
            send_byte(1, b, i == 29, (stall_at < 0) ? 8 : 2000, ok);
            if (!ok && stall_at < 0) begin
                stall_at = i;
                rdy_b = 1'b1;
                send_byte(1, b, i == 29, 2000, ok);
            end
            if (!ok) post("t4_send_timeout", 0, 1);
        end
        // Two bytes of the first frame already sit in the output registers,
        // so 26 bytes of the second frame fit before backpressure.
        post("t4_stall_at", stall_at, 26);
        wait_drain(1, 500);
        post("t4_drops", drop_cnt[1], 0);
        post("t4_fc_after", fc_b, 0);

        // 5: oversized frame into an empty small buffer is discarded
        for (int i = 0; i < 99; i++) begin
            send_byte(1, 8'(i), 1'b0, 8, ok);
            if (!ok) post("t5_send_timeout", i, -1);
        end
        @(negedge clk);
        post("t5_drop_before_last", drop_cnt[1], 0);
        post("t5_fc_mid", fc_b, 0);
        @(posedge clk); #1;
        send_byte(1, 8'd99, 1'b1, 8, ok);
        if (!ok) post("t5_send_timeout", 99, -1);
        repeat (2) @(negedge clk);
        post("t5_drop_once", drop_cnt[1], 1);
        post("t5_fc_zero", fc_b, 0);
        post("t5_no_output", out_b.tvalid, 0);
        @(posedge clk); #1;
        send_frame(1, 10, 8'h5A, 1);
        wait_drain(1, 200);
        post("t5_drop_final", drop_cnt[1], 1);

        // 6: reset mid-frame, then coincident commit and output tlast
        rdy_a = 1'b0;
        send_frame(0, 5, 8'h90, 0);
        for (int i = 0; i < 20; i++) send_byte(0, 8'(i), 1'b0, 8, ok);
        rstn = 1'b0;
        #2;
        post("t6_rst_in_tready", in_a.tready, 0);
        post("t6_rst_out_tvalid", out_a.tvalid, 0);
        post("t6_rst_out_tdata", out_a.tdata, 0);
        post("t6_rst_out_tlast", out_a.tlast, 0);
        post("t6_rst_fc", fc_a, 0);
        post("t6_rst_drop", drop_a, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        send_frame(0, 1, 8'hA5, 1);
        for (int i = 0; i < 8; i++) q_push(0, {i == 7, 8'h20 + 8'(i)});
        for (int i = 0; i < 7; i++) send_byte(0, 8'h20 + 8'(i), 1'b0, 8, ok);
        repeat (3) @(negedge clk);
        post("t6_fc_one", fc_a, 1);
        @(posedge clk); #1;
        d_sel = 1'b0; d_tdata = 8'h27; d_tlast = 1'b1; d_tvalid = 1'b1;
        rdy_a = 1'b1;
        @(negedge clk);
        post("t6_coinc_in_rdy", in_a.tready, 1);
        post("t6_coinc_out_last", out_a.tvalid && out_a.tlast, 1);
        @(posedge clk); #1;
        d_tvalid = 1'b0; d_tlast = 1'b0;
        rdy_a = 1'b0;
        @(negedge clk);
        post("t6_fc_unchanged", fc_a, 1);
        @(posedge clk); #1;
        rdy_a = 1'b1;
        wait_drain(0, 200);
        post("t6_fc_after", fc_a, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
